// File: rtl/frame_reader.sv
// Frame reader: fetches a frame as 16-pixel read bursts and streams the pixels into a store FIFO.
// Optional read timeout with sticky error is built when FRAME_READER_TIMEOUT_EN is defined.
//
// state     | meaning
// IDLE      | waiting for init_done before issuing the next burst
// CMD       | one-cycle read command for the current burst address
// WAIT_DATA | collecting 8 read beats into the burst buffer
// DRAIN     | writing 16 buffered pixels to the store FIFO, stalling while full
// ERROR     | read timeout; all strobes held low until reset
module frame_reader #(
    parameter int          FRAME_WIDTH    = 640,
    parameter int          FRAME_HEIGHT   = 480,
    parameter logic [20:0] BASE_ADDR      = 21'd0,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    output logic        cmd,
    output logic        cmd_en,
    output logic [20:0] addr,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    input  logic        store_queue_full,
    output logic        store_wr_en,
    output logic [16:0] store_queue_data,
    output logic        frame_done,
    output logic        error
);

    localparam int NUM_BURSTS = (FRAME_WIDTH * FRAME_HEIGHT) / 16;
    localparam int BIDX_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BIDX_W-1:0] LAST_BURST = BIDX_W'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {IDLE, CMD, WAIT_DATA, DRAIN, ERROR} state_t;

    state_t            state, state_nxt;
    logic [20:0]       burst_addr;
    logic [BIDX_W-1:0] burst_idx;
    logic [2:0]        beat_cnt;
    logic [3:0]        pix_idx;
    logic [31:0]       beat_buf [8];
    logic [31:0]       cur_beat;
    logic [15:0]       cur_pix;
    logic              beat_take;
    logic              last_beat;
    logic              burst_end;
    logic              timed_out;

    assign beat_take = (state == WAIT_DATA) && rd_data_valid;
    assign last_beat = beat_take && (beat_cnt == 3'd7);
    assign burst_end = (state == DRAIN) && !store_queue_full && (pix_idx == 4'd15);
    assign cur_beat  = beat_buf[pix_idx[3:1]];
    assign cur_pix   = pix_idx[0] ? cur_beat[31:16] : cur_beat[15:0];

`ifdef FRAME_READER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             error_q;

    // Loaded with TIMEOUT_CYCLES-2 so ERROR is entered exactly TIMEOUT_CYCLES after the CMD cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == CMD)
                tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 2);
            else if (state == WAIT_DATA && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;
            if (state_nxt == ERROR)
                error_q <= 1'b1;
        end
    end

    assign timed_out = (state == WAIT_DATA) && (tmo_cnt == '0);
    assign error     = error_q;
`else
    assign timed_out = 1'b0;
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            burst_addr <= BASE_ADDR;
            burst_idx  <= '0;
            beat_cnt   <= '0;
            pix_idx    <= '0;
        end else begin
            state <= state_nxt;
            if (state == CMD)
                beat_cnt <= '0;
            else if (beat_take)
                beat_cnt <= beat_cnt + 3'd1;
            if (state == DRAIN && !store_queue_full)
                pix_idx <= pix_idx + 4'd1;
            if (burst_end) begin
                if (burst_idx == LAST_BURST) begin
                    burst_addr <= BASE_ADDR;
                    burst_idx  <= '0;
                end else begin
                    burst_addr <= burst_addr + 21'd16;
                    burst_idx  <= burst_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_take)
            beat_buf[beat_cnt] <= rd_data;
    end

    always_comb begin
        state_nxt        = state;
        cmd              = 1'b0;
        cmd_en           = 1'b0;
        addr             = burst_addr;
        store_wr_en      = 1'b0;
        store_queue_data = '0;
        frame_done       = 1'b0;
        case (state)
            IDLE: begin
                if (init_done)
                    state_nxt = CMD;
            end
            CMD: begin
                cmd_en    = 1'b1;
                state_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                // A final beat landing on the last allowed cycle wins over the timeout.
                if (last_beat)
                    state_nxt = DRAIN;
                else if (timed_out)
                    state_nxt = ERROR;
            end
            DRAIN: begin
                store_wr_en      = !store_queue_full;
                store_queue_data = {(burst_idx == '0) && (pix_idx == 4'd0), cur_pix};
                frame_done       = burst_end && (burst_idx == LAST_BURST);
                if (burst_end)
                    state_nxt = init_done ? CMD : IDLE;
            end
            ERROR: state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader: randomized memory/FIFO behaviour against a frame-level reference.
// Build with FRAME_READER_TIMEOUT_EN defined to also exercise the read timeout.
module tb_frame_reader;

    localparam int          W    = 32;
    localparam int          H    = 4;
    localparam int          N    = W * H;
    localparam int          NB   = N / 16;
    localparam logic [20:0] BASE = 21'h1FFFC0;
    localparam int          TMO  = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_done = 1'b0;
    logic        cmd, cmd_en;
    logic [20:0] addr;
    logic [31:0] rd_data = '0;
    logic        rd_data_valid = 1'b0;
    logic        store_queue_full = 1'b0;
    logic        store_wr_en;
    logic [16:0] store_queue_data;
    logic        frame_done;
    logic        error;

    frame_reader #(
        .FRAME_WIDTH   (W),
        .FRAME_HEIGHT  (H),
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .init_done       (init_done),
        .cmd             (cmd),
        .cmd_en          (cmd_en),
        .addr            (addr),
        .rd_data         (rd_data),
        .rd_data_valid   (rd_data_valid),
        .store_queue_full(store_queue_full),
        .store_wr_en     (store_wr_en),
        .store_queue_data(store_queue_data),
        .frame_done      (frame_done),
        .error           (error)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int beat_limit = 8;
    bit rand_gaps  = 1'b1;
    bit rand_full  = 1'b0;
    bit spurious   = 1'b1;
    bit force_full = 1'b0;

    logic [20:0] cmd_log[$];
    logic [16:0] wr_log[$];
    int          done_at[$];
    int          beats_seen = 0;
    int          cycle = 0;
    int          cmd_cycle = 0;
    int          err_cycle = -1;
    int          proto_viol = 0;
    int          strobe_after_err = 0;
    bit          prev_cmd_en = 1'b0;

    // Reference: command j targets burst (j mod NB); write i carries halfword (i mod N) of the frame.
    function automatic logic [20:0] exp_cmd(int j);
        return BASE + 21'(16 * (j % NB));
    endfunction

    function automatic logic [16:0] exp_wr(int i);
        int          p;
        logic [20:0] a;
        p = i % N;
        a = BASE + 21'(p);
        return {(p == 0), a[15:0]};
    endfunction

    always @(negedge clk) begin
        cycle++;
        if (reset) begin
            prev_cmd_en = 1'b0;
        end else begin
            if (cmd !== 1'b0) proto_viol++;
            if (cmd_en === 1'b1) begin
                if (prev_cmd_en) proto_viol++;
                cmd_log.push_back(addr);
                cmd_cycle = cycle;
            end
            prev_cmd_en = (cmd_en === 1'b1);
            if (rd_data_valid) beats_seen++;
            if (store_wr_en === 1'b1) begin
                if (store_queue_full) proto_viol++;
                wr_log.push_back(store_queue_data);
            end
            if (frame_done === 1'b1) done_at.push_back(wr_log.size());
            if (error === 1'b1 && err_cycle < 0) err_cycle = cycle;
            if (error === 1'b1 && (cmd_en === 1'b1 || store_wr_en === 1'b1 || frame_done === 1'b1))
                strobe_after_err++;
        end
    end

    // Memory: 4-cycle latency, halfword index as data, random gaps, stray beats when nothing is pending.
    logic [20:0] mem_addr;
    int          mem_delay;
    int          mem_beat;
    bit          mem_active = 1'b0;

    always begin
        logic [20:0] a0, a1;
        @(posedge clk);
        #2;
        rd_data_valid = 1'b0;
        rd_data       = '0;
        if (reset) begin
            mem_active = 1'b0;
        end else if (cmd_en === 1'b1) begin
            mem_active = 1'b1;
            mem_addr   = addr;
            mem_delay  = 4;
            mem_beat   = 0;
        end else if (mem_active) begin
            if (mem_delay > 0) mem_delay--;
            if (mem_delay == 0 && !(rand_gaps && $urandom_range(0, 3) == 0)) begin
                a0 = mem_addr + 21'(2 * mem_beat);
                a1 = a0 + 21'd1;
                rd_data       = {a1[15:0], a0[15:0]};
                rd_data_valid = 1'b1;
                mem_beat++;
                if (mem_beat >= beat_limit) mem_active = 1'b0;
            end
        end else if (spurious && $urandom_range(0, 4) == 0) begin
            rd_data       = $urandom;
            rd_data_valid = 1'b1;
        end
    end

    always begin
        @(posedge clk);
        #2;
        store_queue_full = force_full | (rand_full && $urandom_range(0, 2) == 0);
    end

    task automatic clear_logs();
        cmd_log.delete();
        wr_log.delete();
        done_at.delete();
        beats_seen       = 0;
        err_cycle        = -1;
        proto_viol       = 0;
        strobe_after_err = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        clear_logs();
        reset = 1'b0;
    endtask

    task automatic wait_writes(int n, int budget, string tag);
        int k;
        k = 0;
        while (wr_log.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        tests_run++;
        if (wr_log.size() < n) begin
            tests_failed++;
            $display("FAIL %s_timeout: writes=%0d required=%0d", tag, wr_log.size(), n);
        end
    endtask

    task automatic check_stream(int ncmd, int nwr, string tag);
        tests_run++;
        if (cmd_log.size() < ncmd) begin
            tests_failed++;
            $display("FAIL %s_cmd_count: got %0d required %0d", tag, cmd_log.size(), ncmd);
        end
        for (int j = 0; j < ncmd && j < cmd_log.size(); j++) begin
            tests_run++;
            if (cmd_log[j] !== exp_cmd(j)) begin
                tests_failed++;
                $display("FAIL %s_cmd_addr[%0d]: got %h required %h", tag, j, cmd_log[j], exp_cmd(j));
                break;
            end
        end
        for (int i = 0; i < nwr && i < wr_log.size(); i++) begin
            tests_run++;
            if (wr_log[i] !== exp_wr(i)) begin
                tests_failed++;
                $display("FAIL %s_wr_data[%0d]: got %h required %h", tag, i, wr_log[i], exp_wr(i));
                break;
            end
        end
        tests_run++;
        if (proto_viol !== 0) begin
            tests_failed++;
            $display("FAIL %s_protocol: violations %0d required 0", tag, proto_viol);
        end
    endtask

    task automatic test_reset();
        init_done = 1'b1;
        reset     = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        tests_run++;
        if ({cmd, cmd_en, store_wr_en, frame_done, error} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b required 00000", {cmd, cmd_en, store_wr_en, frame_done, error});
        end
        tests_run++;
        if (addr !== BASE) begin
            tests_failed++;
            $display("FAIL reset_addr: got %h required %h", addr, BASE);
        end
        tests_run++;
        if (store_queue_data !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h required 0", store_queue_data);
        end
        init_done = 1'b0;
        clear_logs();
        reset = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        tests_run++;
        if (cmd_log.size() !== 0) begin
            tests_failed++;
            $display("FAIL idle_no_init: commands %0d required 0", cmd_log.size());
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        rand_gaps = 1'b1; rand_full = 1'b1; spurious = 1'b1;
        init_done = 1'b1;
        wait_writes(N, 6000, "frame");
        check_stream(NB, N, "frame");
        tests_run++;
        if (done_at.size() !== 1 || (done_at.size() > 0 && done_at[0] !== N)) begin
            tests_failed++;
            $display("FAIL frame_done: pulses %0d first_at %0d required 1 at %0d",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1, N);
        end
        tests_run++;
        if (error !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_error: got %b required 0", error);
        end
        init_done = 1'b0; rand_full = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        rand_gaps = 1'b1; spurious = 1'b1;
        init_done = 1'b1;
        wait_writes(2 * N, 8000, "b2b");
        check_stream(2 * NB, 2 * N, "b2b");
        tests_run++;
        if (done_at.size() !== 2 || (done_at.size() == 2 && (done_at[0] !== N || done_at[1] !== 2 * N))) begin
            tests_failed++;
            $display("FAIL b2b_frame_done: pulses %0d required 2 at %0d and %0d", done_at.size(), N, 2 * N);
        end
        init_done = 1'b0;
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        rand_gaps = 1'b1; spurious = 1'b1;
        init_done = 1'b1;
        wait_writes(19, 400, "bp_pre");
        force_full = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        tests_run++;
        if (wr_log.size() !== 19) begin
            tests_failed++;
            $display("FAIL bp_stalled_writes: got %0d required 19", wr_log.size());
        end
        force_full = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (wr_log.size() !== 20) begin
            tests_failed++;
            $display("FAIL bp_resume: got %0d required 20", wr_log.size());
        end
        k = 0;
        wait_writes(N, 6000, "bp");
        check_stream(NB, N, "bp");
        init_done = 1'b0;
    endtask

    task automatic test_init_drop();
        int k;
        do_reset();
        spurious = 1'b0; rand_gaps = 1'b1;
        init_done = 1'b1;
        k = 0;
        while (beats_seen < 4 && k < 200) begin @(posedge clk); #1; k++; end
        init_done = 1'b0;
        wait_writes(16, 400, "drop");
        repeat (40) begin @(posedge clk); #1; end
        tests_run++;
        if (wr_log.size() !== 16 || cmd_log.size() !== 1) begin
            tests_failed++;
            $display("FAIL drop_hold: writes %0d cmds %0d required 16 and 1", wr_log.size(), cmd_log.size());
        end
        check_stream(1, 16, "drop");
        init_done = 1'b1;
        k = 0;
        while (cmd_log.size() < 2 && k < 20) begin @(posedge clk); #1; k++; end
        tests_run++;
        if (cmd_log.size() < 2 || cmd_log[1] !== exp_cmd(1)) begin
            tests_failed++;
            $display("FAIL drop_resume: cmds %0d addr %h required %h",
                     cmd_log.size(), (cmd_log.size() > 1) ? cmd_log[1] : 21'h0, exp_cmd(1));
        end
        init_done = 1'b0; spurious = 1'b1;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        init_done = 1'b1;
        wait_writes(16 + 7, 800, "mid_pre");
        reset = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        reset = 1'b0;
        wait_writes(1, 200, "mid_first");
        tests_run++;
        if (cmd_log.size() < 1 || cmd_log[0] !== BASE) begin
            tests_failed++;
            $display("FAIL mid_restart_addr: got %h required %h", (cmd_log.size() > 0) ? cmd_log[0] : 21'h0, BASE);
        end
        tests_run++;
        if (wr_log.size() < 1 || wr_log[0] !== {1'b1, BASE[15:0]}) begin
            tests_failed++;
            $display("FAIL mid_first_write: got %h required %h", (wr_log.size() > 0) ? wr_log[0] : 17'h0, {1'b1, BASE[15:0]});
        end
        wait_writes(N, 6000, "mid");
        check_stream(NB, N, "mid");
        init_done = 1'b0;
    endtask

`ifdef FRAME_READER_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        do_reset();
        spurious = 1'b0; rand_gaps = 1'b0; beat_limit = 5;
        init_done = 1'b1;
        k = 0;
        while (err_cycle < 0 && k < 4 * TMO) begin @(posedge clk); #1; k++; end
        tests_run++;
        if (err_cycle < 0 || err_cycle - cmd_cycle !== TMO) begin
            tests_failed++;
            $display("FAIL tmo_latency: got %0d required %0d", (err_cycle < 0) ? -1 : err_cycle - cmd_cycle, TMO);
        end
        repeat (30) begin @(posedge clk); #1; end
        tests_run++;
        if (strobe_after_err !== 0 || cmd_log.size() !== 1 || wr_log.size() !== 0 || error !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_quiet: strobes %0d cmds %0d writes %0d error %b required 0 1 0 1",
                     strobe_after_err, cmd_log.size(), wr_log.size(), error);
        end
        beat_limit = 8; init_done = 1'b0;
        do_reset();
        @(posedge clk); #1;
        tests_run++;
        if (error !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_clear: got %b required 0", error);
        end
        spurious = 1'b1; rand_gaps = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_init_drop();
        test_reset_mid_drain();
`ifdef FRAME_READER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter FRAME_WIDTH, default 640, pixels per line.
REQ-002 Parameter FRAME_HEIGHT, default 480, lines per frame; FRAME_WIDTH*FRAME_HEIGHT SHALL be a multiple of 16.
REQ-003 Parameter BASE_ADDR, default 0, 21-bit halfword address of pixel 0.
REQ-004 Parameter TIMEOUT_CYCLES, default 256, maximum cycles from read command to final data beat.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 init_done  input  1  memory controller ready.
REQ-008 cmd  output  1  command type; 0 = read, always 0 from this block.
REQ-009 cmd_en  output  1  command strobe, one cycle per burst.
REQ-010 addr  output  21  halfword burst start address.
REQ-011 rd_data  input  32  read beat; [15:0] = pixel at addr, [31:16] = pixel at addr+1.
REQ-012 rd_data_valid  input  1  rd_data qualifier.
REQ-013 store_queue_full  input  1  downstream FIFO full.
REQ-014 store_wr_en  output  1  FIFO write strobe.
REQ-015 store_queue_data  output  17  [15:0] RGB565 pixel, [16] = frame-start flag.
REQ-016 frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.
REQ-017 error  output  1  sticky read-timeout flag.

Function
REQ-018 Burst = one read command + 8 data beats = 16 pixels; address advances by 16 per burst.
REQ-019 States: IDLE, CMD, WAIT_DATA, DRAIN, ERROR.
REQ-020 IDLE -> CMD when init_done=1; otherwise stay in IDLE.
REQ-021 CMD asserts cmd_en=1, cmd=0, addr=current burst address for exactly one cycle, then enters WAIT_DATA.
REQ-022 WAIT_DATA stores beat k (k=0..7) in an 8x32 buffer on each rd_data_valid=1 cycle; after beat 7 it enters DRAIN on the next cycle.
REQ-023 rd_data_valid outside WAIT_DATA, and beats beyond the 8th, SHALL be ignored.
REQ-024 DRAIN writes the buffer in order: beat k[15:0] as pixel 2k, then beat k[31:16] as pixel 2k+1.
REQ-025 DRAIN asserts store_wr_en=1 only in cycles where store_queue_full=0; when full, store_wr_en=0 and the current pixel is held unchanged.
REQ-026 store_queue_data[16]=1 only for pixel 0 of each frame; otherwise 0.
REQ-027 After pixel 15 of a burst that is not the last burst of the frame: address+16, then CMD if init_done=1, else IDLE.
REQ-028 After pixel 15 of the last burst: frame_done=1 for one cycle, address reloads BASE_ADDR, then CMD or IDLE per init_done.
REQ-029 init_done dropping mid-burst SHALL NOT abort the burst; it takes effect only at the burst boundary.
REQ-030 Address arithmetic is 21-bit modulo; a frame end never wraps past BASE_ADDR+FRAME_WIDTH*FRAME_HEIGHT-1.
REQ-031 cmd_en, store_wr_en and frame_done SHALL be deasserted in every state other than the one defined to drive them.

Reset
REQ-032 On reset=1 at a clk edge: state=IDLE, address=BASE_ADDR, buffer beat count=0, pixel index=0, timeout counter=0.
REQ-033 Reset outputs: cmd=0, cmd_en=0, addr=BASE_ADDR, store_wr_en=0, store_queue_data=0, frame_done=0, error=0.
REQ-034 Reset asserted in any state, including mid-drain, discards buffered pixels and restarts at frame pixel 0.

Configuration
REQ-035 Macro FRAME_READER_TIMEOUT_EN defined: a counter starts at CMD, and if 8 beats are not received within TIMEOUT_CYCLES cycles the block enters ERROR, with error=1 and all strobes 0 until reset.
REQ-036 Macro FRAME_READER_TIMEOUT_EN undefined: no counter exists, error is tied to 0, the ERROR state is unreachable, and WAIT_DATA waits indefinitely.

Verification
REQ-037 640x20 frame, memory model returns the halfword index as data with 4-cycle latency, FIFO never full -> 800 read commands at addr 0,16,...,12784; 12800 writes with data=index; bit16=1 on write 0 only; one frame_done.
REQ-038 store_queue_full held high for 10 cycles during a drain -> store_wr_en=0 for exactly those cycles; no pixel lost or duplicated; order preserved.
REQ-039 Two consecutive frames -> second frame's first command at addr=BASE_ADDR with bit16=1; exactly two frame_done pulses.
REQ-040 init_done dropped after beat 3 of a burst -> burst completes and all 16 pixels are written; no further cmd_en until init_done=1.
REQ-041 FRAME_READER_TIMEOUT_EN defined, only 5 beats returned -> error=1 at cycle TIMEOUT_CYCLES after cmd_en; no further strobes; reset clears error.
REQ-042 Reset pulsed while in DRAIN at pixel 7 -> next command at BASE_ADDR; first write after reset has bit16=1.
